// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter funnelling NUM_CH line-sized read/write requests onto one memory bus.
// Optional feature macro ARB_WRITE_ACK_EN: when defined, each write returns a one-beat processor response (WRESP).
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif
module bus_arbiter_rr #(
    parameter int NUM_CH         = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                req_cyc,
    output logic [NUM_CH-1:0]                req_ack,
    input  logic [NUM_CH*BUS_DATA_WIDTH-1:0] req,
    input  logic [NUM_CH*BUS_TAG_WIDTH-1:0]  req_tag,
    output logic [NUM_CH-1:0]                resp_cyc,
    input  logic [NUM_CH-1:0]                resp_ack,
    output logic [BUS_DATA_WIDTH-1:0]        resp,
    output logic [BUS_TAG_WIDTH-1:0]         resp_tag,
    output logic                             bus_reqcyc,
    input  logic                             bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]        bus_req,
    output logic [BUS_TAG_WIDTH-1:0]         bus_reqtag,
    input  logic                             bus_respcyc,
    output logic                             bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]        bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]         bus_resptag
);
    localparam int GW = $clog2(NUM_CH);
    localparam int PW = $clog2(LINE_BEATS);
    localparam logic [PW-1:0] LAST = PW'(LINE_BEATS - 1);

`ifdef ARB_WRITE_ACK_EN
    typedef enum logic [2:0] {IDLE, ACK, WCOLLECT, BADDR, BWDATA, BRECV, RESP, WRESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ACK, WCOLLECT, BADDR, BWDATA, BRECV, RESP} state_t;
`endif

    state_t                    r_state;
    logic [GW-1:0]             r_last;
    logic [PW-1:0]             r_ptr;
    logic [BUS_DATA_WIDTH-1:0] r_addr;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic [BUS_DATA_WIDTH-1:0] r_line [LINE_BEATS];

    logic [BUS_DATA_WIDTH-1:0] w_req [NUM_CH];
    logic [BUS_TAG_WIDTH-1:0]  w_tag [NUM_CH];
    logic [GW-1:0]             w_next;
    logic [GW-1:0]             w_idx;
    logic                      w_any;
    logic                      w_write;
    logic                      w_end;
    logic                      w_unused;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
        assign w_req[i] = req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        assign w_tag[i] = req_tag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
    end

    // r_last doubles as the current grant: it only changes when a new grant enters ACK
    assign w_write  = r_tag[BUS_TAG_WIDTH-1] == `SYSBUS_WRITE;
    assign w_end    = r_ptr == LAST;
    assign w_unused = ^bus_resptag;

    // Pick the first requesting channel after the previous grant, wrapping modulo NUM_CH
    always_comb begin
        w_next = r_last;
        w_idx  = r_last;
        w_any  = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = GW'((int'(r_last) + i) % NUM_CH);
            if (!w_any && req_cyc[w_idx]) begin
                w_next = w_idx;
                w_any  = 1'b1;
            end
        end
    end

    // Transfer sequencing and line buffer; ptr wraps to 0 naturally at each line end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= GW'(NUM_CH - 1);
            r_ptr   <= '0;
            r_addr  <= '0;
            r_tag   <= '0;
            for (int i = 0; i < LINE_BEATS; i++) r_line[i] <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_last  <= w_next;
                    r_addr  <= w_req[w_next];
                    r_tag   <= w_tag[w_next];
                    r_state <= ACK;
                end
                ACK: r_state <= w_write ? WCOLLECT : BADDR;
                WCOLLECT: if (req_cyc[r_last]) begin
                    r_line[r_ptr] <= w_req[r_last];
                    r_ptr         <= r_ptr + 1'b1;
                    if (w_end) r_state <= BADDR;
                end
                BADDR: if (bus_reqack) r_state <= w_write ? BWDATA : BRECV;
                BWDATA: if (bus_reqack) begin
                    r_ptr <= r_ptr + 1'b1;
`ifdef ARB_WRITE_ACK_EN
                    if (w_end) r_state <= WRESP;
`else
                    if (w_end) r_state <= IDLE;
`endif
                end
                BRECV: if (bus_respcyc) begin
                    r_line[r_ptr] <= bus_resp;
                    r_ptr         <= r_ptr + 1'b1;
                    if (w_end) r_state <= RESP;
                end
                RESP: if (resp_ack[r_last]) begin
                    r_ptr <= r_ptr + 1'b1;
                    if (w_end) r_state <= IDLE;
                end
`ifdef ARB_WRITE_ACK_EN
                WRESP: if (resp_ack[r_last]) r_state <= IDLE;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decode handshakes from the state; everything is forced low while reset is asserted
    always_comb begin
        req_ack     = '0;
        resp_cyc    = '0;
        resp        = '0;
        resp_tag    = '0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        if (reset) begin
            case (r_state)
                ACK:      req_ack[r_last] = 1'b1;
                WCOLLECT: req_ack[r_last] = req_cyc[r_last];
                BADDR: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = r_addr;
                    bus_reqtag = r_tag;
                end
                BWDATA: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = r_line[r_ptr];
                    bus_reqtag = r_tag;
                end
                BRECV: bus_respack = bus_respcyc;
                RESP: begin
                    resp_cyc[r_last] = 1'b1;
                    resp             = r_line[r_ptr];
                    resp_tag         = r_tag;
                end
`ifdef ARB_WRITE_ACK_EN
                WRESP: begin
                    resp_cyc[r_last] = 1'b1;
                    resp_tag         = r_tag;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
